// File: rtl/rf_pkg.sv
// Shared types for the RegFile writeback path.
package rf_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback FIFO. Exposes every slot in age order (index 0 = head) plus a valid mask
// so the top can run its forwarding search without knowing the pointer layout.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [PW:0]           count,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] slots,
  output logic [DEPTH-1:0]      valid
);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]           wr_q, rd_q;
  logic [PW-1:0]         wr_idx, rd_idx;
  wb_entry_t [DEPTH-1:0] mem_q;

  assign wr_idx = wr_q[PW-1:0];
  assign rd_idx = rd_q[PW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[PW] != rd_q[PW]) && (wr_idx == rd_idx);
  assign count  = wr_q - rd_q;
  assign head   = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= push_entry;
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    slots = '0;
    valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx      = rd_idx + PW'(k);
      slots[k] = mem_q[idx];
      valid[k] = ((PW + 1)'(k) < count);
    end
  end

endmodule

// File: rtl/rf_wb_writer.sv
// RegFile write-side master: queues writeback results, drains one per cycle through the
// shared r strobe against decode reads, and forwards queued values to decode.
module rf_wb_writer
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_DEFER = 3,
  localparam int unsigned PW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            rd_req,
  output logic            rd_gnt,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic            rf_r,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_din,
  output logic [PW:0]     pending
);

  localparam int unsigned DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [DW-1:0] MaxDefer = DW'(MAX_DEFER);

  logic                  full, empty, push, pop;
  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      valid;
  logic [DW-1:0]         defer_q, defer_d;

  // x0 completes the handshake but is dropped here.
  assign wb_ready   = !full;
  assign push       = wb_valid && !full && (wb_rd != '0);
  assign push_entry = '{rd: wb_rd, data: wb_data};

  rf_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (pending),
    .head      (head),
    .slots     (slots),
    .valid     (valid)
  );

  always_comb begin
    rd_gnt  = 1'b0;
    rf_r    = 1'b1;
    pop     = 1'b0;
    defer_d = defer_q;
    if (empty) begin
      rd_gnt = rd_req;
    end else if (!rd_req || defer_q >= MaxDefer) begin
      rf_r    = 1'b0;
      pop     = 1'b1;
      defer_d = '0;
    end else begin
      rd_gnt  = 1'b1;
      defer_d = defer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) defer_q <= '0;
    else     defer_q <= defer_d;
  end

  assign rf_rd  = rf_r ? '0 : head.rd;
  assign rf_din = rf_r ? '0 : head.data;

  // Later slots are younger, so the last match in the scan wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid[k] && (q_rs1 != '0) && (slots[k].rd == q_rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = slots[k].data;
      end
      if (valid[k] && (q_rs2 != '0) && (slots[k].rd == q_rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = slots[k].data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_writer.sv
// Bench for rf_wb_writer: a behavioural RegFile on the write port plus a queue-based model.
module tb_rf_wb_writer;
  import rf_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 3;

  logic            clk, rst;
  logic            wb_valid, wb_ready, rd_req, rd_gnt;
  logic [4:0]      wb_rd, q_rs1, q_rs2, rf_rd;
  logic [31:0]     wb_data, fwd1_data, fwd2_data, rf_din;
  logic            fwd1_hit, fwd2_hit, rf_r;
  logic [2:0]      pending;

  rf_wb_writer #(
    .DEPTH    (DEPTH),
    .MAX_DEFER(MAX_DEFER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_ready (wb_ready),
    .rd_req   (rd_req),
    .rd_gnt   (rd_gnt),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .fwd1_hit (fwd1_hit),
    .fwd1_data(fwd1_data),
    .fwd2_hit (fwd2_hit),
    .fwd2_data(fwd2_data),
    .rf_r     (rf_r),
    .rf_rd    (rf_rd),
    .rf_din   (rf_din),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  ment_t        mq[$];
  int           defer;
  logic [31:0]  rf_ref[32];
  logic [31:0]  rf_dut[32];
  logic         e_write;
  logic [108:0] exp_v;
  wire  [108:0] obs = {wb_ready, rd_gnt, rf_r, rf_rd, rf_din, pending,
                       fwd1_hit, fwd1_data, fwd2_hit, fwd2_data};
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [32:0] fwd_lookup(logic [4:0] q);
    for (int k = mq.size() - 1; k >= 0; k--)
      if (q != 5'd0 && mq[k].rd == q) return {1'b1, mq[k].data};
    return 33'd0;
  endfunction

  function automatic void model_eval();
    logic [4:0]  ord;
    logic [31:0] odin;
    logic        ready;
    ready   = (mq.size() < DEPTH);
    e_write = (mq.size() != 0) && (!rd_req || defer >= MAX_DEFER);
    ord     = 5'd0;
    odin    = 32'd0;
    if (e_write) begin
      ord  = mq[0].rd;
      odin = mq[0].data;
    end
    exp_v = {ready, rd_req && !e_write, !e_write, ord, odin, 3'(mq.size()),
             fwd_lookup(q_rs1), fwd_lookup(q_rs2)};
  endfunction

  // Called at the negedge after model_eval: commits RegFile + model, moves past the edge.
  task automatic advance();
    bit ready;
    if (!rst && !rf_r) rf_dut[rf_rd] = rf_din;
    if (rst) begin
      mq.delete();
      defer = 0;
    end else begin
      ready = (mq.size() < DEPTH);
      if (e_write) begin
        rf_ref[mq[0].rd] = mq[0].data;
        void'(mq.pop_front());
        defer = 0;
      end else if (mq.size() != 0 && rd_req) begin
        defer++;
      end
      if (wb_valid && ready && wb_rd != 5'd0) mq.push_back('{wb_rd, wb_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic req, input logic [4:0] s1, input logic [4:0] s2);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
    rd_req   = req;
    q_rs1    = s1;
    q_rs2    = s2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    advance();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_req = (i == 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      n_checks++;
      if (pending !== 3'd0 || rf_r !== 1'b1 || wb_ready !== 1'b1 || rd_gnt !== rd_req) begin
        n_fail++;
        $display("FAIL reset_state: pending=%0d rf_r=%b ready=%b gnt=%b want 0 1 1 %b",
                 pending, rf_r, wb_ready, rd_gnt, rd_req);
      end
      advance();
    end
  endtask

  task automatic test_basic_write();
    int writes = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1, 5, 150, 0, 0, 0);
      else if (i == 1) drive(1, 10, 300, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic_write c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      if (rf_r === 1'b0) writes++;
      advance();
    end
    n_checks++;
    if (writes != 2 || rf_dut[5] !== 32'd150 || rf_dut[10] !== 32'd300) begin
      n_fail++;
      $display("FAIL basic_readback: writes=%0d r5=%0d r10=%0d want 2 150 300",
               writes, rf_dut[5], rf_dut[10]);
    end
  endtask

  task automatic test_defer();
    int gnts = 0;
    bit seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1, 25, 53, 1, 0, 0);
      else        drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL defer c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      if (i > 0 && !seen) begin
        if (rf_r === 1'b0) begin
          seen = 1;
          n_checks++;
          if (rd_gnt !== 1'b0 || rf_rd !== 5'd25 || rf_din !== 32'd53) begin
            n_fail++;
            $display("FAIL defer_forced: gnt=%b rd=%0d din=%0d want 0 25 53",
                     rd_gnt, rf_rd, rf_din);
          end
        end else if (rd_gnt === 1'b1) begin
          gnts++;
        end
      end
      advance();
    end
    n_checks++;
    if (!seen || gnts != MAX_DEFER) begin
      n_fail++;
      $display("FAIL defer_count: forced=%0d grants=%0d want 1 %0d", seen, gnts, MAX_DEFER);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1, 7, 1, 1, 7, 0);
        1:       drive(1, 7, 2, 1, 7, 7);
        2:       drive(0, 0, 0, 1, 7, 7);
        default: drive(0, 0, 0, 0, 7, 7);
      endcase
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL forward c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      if (i == 2) begin
        n_checks++;
        if (fwd1_hit !== 1'b1 || fwd1_data !== 32'd2) begin
          n_fail++;
          $display("FAIL forward_youngest: hit=%b data=%0d want 1 2", fwd1_hit, fwd1_data);
        end
      end
      advance();
    end
    n_checks++;
    if (fwd1_hit !== 1'b0 || rf_dut[7] !== 32'd2) begin
      n_fail++;
      $display("FAIL forward_drained: hit=%b r7=%0d want 0 2", fwd1_hit, rf_dut[7]);
    end
  endtask

  task automatic test_full();
    bit saw_full = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) drive(1, 5'(11 + i), $urandom, 1, 5'(11 + i), 12);
      else       drive(0, 0, 0, 0, 13, 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL full c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      if (mq.size() == DEPTH) begin
        saw_full = 1;
        n_checks++;
        if (wb_ready !== 1'b0 || pending !== 3'd4) begin
          n_fail++;
          $display("FAIL full_flags: ready=%b pending=%0d want 0 4", wb_ready, pending);
        end
      end
      advance();
    end
    n_checks++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL full_reached: got 0 want 1");
    end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1, 0, 99, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL x0 c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      n_checks++;
      if (wb_ready !== 1'b1 || pending !== 3'd0 || rf_r !== 1'b1 || fwd1_hit !== 1'b0
          || fwd1_data !== 32'd0) begin
        n_fail++;
        $display("FAIL x0_dropped: ready=%b pending=%0d rf_r=%b hit=%b data=%0d want 1 0 1 0 0",
                 wb_ready, pending, rf_r, fwd1_hit, fwd1_data);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] pre[3];
    for (int k = 0; k < 3; k++) pre[k] = rf_dut[20 + k];
    for (int i = 0; i < 8; i++) begin
      rst = (i == 3);
      if (i < 3)       drive(1, 5'(20 + i), 32'(1000 + i), 1, 20, 22);
      else if (i == 3) drive(0, 0, 0, 1, 20, 22);
      else             drive(0, 0, 0, 0, 20, 22);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      if (i == 4) begin
        n_checks++;
        if (pending !== 3'd0 || rf_r !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid_flush: pending=%0d rf_r=%b want 0 1", pending, rf_r);
        end
      end
      advance();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rf_dut[20 + k] !== pre[k]) begin
        n_fail++;
        $display("FAIL reset_mid_nowrite r%0d: got %0d want %0d", 20 + k, rf_dut[20 + k], pre[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(3) != 0, 5'($urandom_range(7)), $urandom, $urandom_range(1) == 1,
            5'($urandom_range(7)), 5'($urandom_range(7)));
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      advance();
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_drain c%0d: dut=%h model=%h", i, obs, exp_v);
      end
      advance();
    end
    for (int r = 0; r < 32; r++) begin
      n_checks++;
      if (rf_dut[r] !== rf_ref[r]) begin
        n_fail++;
        $display("FAIL regfile r%0d: got %h want %h", r, rf_dut[r], rf_ref[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf_ref[r] = 32'd0;
      rf_dut[r] = 32'd0;
    end
    defer = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic_write();
    test_defer();
    test_forward();
    test_full();
    test_x0();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
